// File: rtl/javk_fetch_pkg.sv
// ============================================================================
// javk_fetch_pkg : fetch FSM state encoding and opcode length table
// Rev 1.0
// ============================================================================
`default_nettype none

package javk_fetch_pkg;

  typedef enum logic [2:0] {
    FS_OP    = 3'd0,
    FS_B1    = 3'd1,
    FS_B2    = 3'd2,
    FS_HOLD  = 3'd3,
    FS_DRAIN = 3'd4
  } fetch_state_t;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  // Length class is opcode[7:6]; shared with decode so both agree on sizing.
  function automatic logic [1:0] len_from_class(input logic [1:0] cls);
    case (cls)
      2'b00:   return LEN_1;
      2'b01:   return LEN_2;
      default: return LEN_3;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/javk_fetch_len.sv
// ============================================================================
// javk_fetch_len : combinational opcode -> instruction length decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module javk_fetch_len
  import javk_fetch_pkg::*;
(
  input  logic [7:0] op,
  output logic [1:0] len
);

  assign len = len_from_class(op[7:6]);

endmodule

`default_nettype wire

// File: rtl/javk_fetch.sv
// ============================================================================
// javk_fetch : JAVK instruction fetch, byte reads assembled into 1-3 byte insns
// Rev 1.0
// ============================================================================
`default_nettype none

module javk_fetch
  import javk_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        bus_req,
  output logic [15:0] bus_addr,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [7:0]  insn_op,
  output logic [15:0] insn_imm,
  output logic [1:0]  insn_len,
  output logic [15:0] insn_pc,
  input  logic        redir_valid,
  input  logic [15:0] redir_addr
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  pc_inc;
  logic [1:0]   rdata_len;

  javk_fetch_len u_len (
    .op  (bus_rdata),
    .len (rdata_len)
  );

  assign pc_inc = pc + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FS_OP;
      pc         <= RESET_VEC;
      bus_req    <= 1'b0;
      bus_addr   <= RESET_VEC;
      insn_valid <= 1'b0;
      insn_op    <= 8'h00;
      insn_imm   <= 16'h0000;
      insn_len   <= 2'd0;
      insn_pc    <= 16'h0000;
    end else if (redir_valid) begin
      // Any partial instruction is dropped; an unacked read must still be drained.
      pc         <= redir_addr;
      insn_valid <= 1'b0;
      if (bus_req && !bus_ack) begin
        state <= FS_DRAIN;
      end else begin
        state    <= FS_OP;
        bus_req  <= 1'b1;
        bus_addr <= redir_addr;
      end
    end else begin
      case (state)
        FS_OP: begin
          if (!bus_req) begin
            bus_req  <= 1'b1;
            bus_addr <= pc;
          end else if (bus_ack) begin
            insn_op  <= bus_rdata;
            insn_len <= rdata_len;
            insn_pc  <= pc;
            insn_imm <= 16'h0000;
            pc       <= pc_inc;
            if (rdata_len == LEN_1) begin
              state      <= FS_HOLD;
              bus_req    <= 1'b0;
              insn_valid <= 1'b1;
            end else begin
              state    <= FS_B1;
              bus_addr <= pc_inc;
            end
          end
        end

        FS_B1: begin
          if (!bus_req) begin
            bus_req  <= 1'b1;
            bus_addr <= pc;
          end else if (bus_ack) begin
            insn_imm <= {8'h00, bus_rdata};
            pc       <= pc_inc;
            if (insn_len == LEN_2) begin
              state      <= FS_HOLD;
              bus_req    <= 1'b0;
              insn_valid <= 1'b1;
            end else begin
              state    <= FS_B2;
              bus_addr <= pc_inc;
            end
          end
        end

        FS_B2: begin
          if (!bus_req) begin
            bus_req  <= 1'b1;
            bus_addr <= pc;
          end else if (bus_ack) begin
            insn_imm[15:8] <= bus_rdata;
            pc             <= pc_inc;
            state          <= FS_HOLD;
            bus_req        <= 1'b0;
            insn_valid     <= 1'b1;
          end
        end

        FS_HOLD: begin
          if (insn_ready) begin
            insn_valid <= 1'b0;
            state      <= FS_OP;
            bus_req    <= 1'b1;
            bus_addr   <= pc;
          end
        end

        FS_DRAIN: begin
          // Stale data discarded; the next read follows back-to-back at the new pc.
          if (bus_ack) begin
            state    <= FS_OP;
            bus_req  <= 1'b1;
            bus_addr <= pc;
          end
        end

        default: begin
          state   <= FS_OP;
          bus_req <= 1'b0;
        end
      endcase
    end
  end

  ack_needs_req: assert property (@(posedge clk) disable iff (rst) bus_ack |-> bus_req);

endmodule

`default_nettype wire

// File: tb/tb_javk_fetch.sv
// ============================================================================
// tb_javk_fetch : directed vector bench for javk_fetch with a byte memory model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_javk_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic [7:0]  bus_rdata = 8'h00;
  logic        insn_valid;
  logic        insn_ready;
  logic [7:0]  insn_op;
  logic [15:0] insn_imm;
  logic [1:0]  insn_len;
  logic [15:0] insn_pc;
  logic        redir_valid;
  logic [15:0] redir_addr;

  javk_fetch #(.RESET_VEC(16'h0100)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_req     (bus_req),
    .bus_addr    (bus_addr),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .insn_valid  (insn_valid),
    .insn_ready  (insn_ready),
    .insn_op     (insn_op),
    .insn_imm    (insn_imm),
    .insn_len    (insn_len),
    .insn_pc     (insn_pc),
    .redir_valid (redir_valid),
    .redir_addr  (redir_addr)
  );

  always #5 clk = ~clk;

  // Byte memory answering after ack_delay full cycles of request
  logic [7:0]  mem [0:65535];
  int          ack_delay = 1;
  int          cnt = 0;
  logic [15:0] addr_log [$];

  always @(negedge clk) begin
    if (rst || !bus_req) begin
      bus_ack = 1'b0;
      cnt     = 0;
    end else if (bus_ack) begin
      bus_ack   = 1'b0;
      bus_rdata = 8'hEE;
      cnt       = 1;
    end else begin
      cnt = cnt + 1;
      if (cnt > ack_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = mem[bus_addr];
        addr_log.push_back(bus_addr);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic redirect(input logic [15:0] a);
    redir_addr  = a;
    redir_valid = 1'b1;
    step();
    redir_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!insn_valid && n < 60) begin
      step();
      n++;
    end
    if (!insn_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: insn_valid got 0 expected 1 (timeout)", name);
    end
  endtask

  task automatic wait_addr(input string name, input logic [15:0] a);
    int n = 0;
    while (!(bus_req && bus_addr == a) && n < 60) begin
      step();
      n++;
    end
    if (!(bus_req && bus_addr == a)) begin
      checks++;
      errors++;
      $display("FAIL %s: bus_addr got %0h expected %0h (timeout)", name, bus_addr, a);
    end
  endtask

  task automatic accept();
    insn_ready = 1'b1;
    step();
    insn_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [1:0]  len;
    logic [15:0] imm;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [63:0] snap;
    logic        ok;
    int          n;
    logic [15:0] next_addr;

    vecs[0] = '{16'h0200, 8'h80, 8'h34, 8'h12, 2'd3, 16'h1234};
    vecs[1] = '{16'h0210, 8'h41, 8'h7F, 8'h00, 2'd2, 16'h007F};
    vecs[2] = '{16'h0220, 8'h3C, 8'h00, 8'h00, 2'd1, 16'h0000};
    vecs[3] = '{16'h0230, 8'hC5, 8'hAA, 8'h55, 2'd3, 16'h55AA};
    vecs[4] = '{16'h0240, 8'h7E, 8'h01, 8'h00, 2'd2, 16'h0001};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h05;
    for (int i = 0; i < 5; i++) begin
      mem[vecs[i].addr]         = vecs[i].b0;
      mem[vecs[i].addr + 16'd1] = vecs[i].b1;
      mem[vecs[i].addr + 16'd2] = vecs[i].b2;
    end
    mem[16'h0400] = 8'h41; mem[16'h0401] = 8'h99;
    mem[16'h0500] = 8'h80; mem[16'h0501] = 8'h11; mem[16'h0502] = 8'h22;
    mem[16'h0300] = 8'h01;
    mem[16'hFFFF] = 8'hC0; mem[16'h0000] = 8'hEF; mem[16'h0001] = 8'hBE;
    mem[16'h0600] = 8'h90; mem[16'h0601] = 8'hAB; mem[16'h0602] = 8'hCD;

    rst         = 1'b1;
    insn_ready  = 1'b0;
    redir_valid = 1'b0;
    redir_addr  = 16'h0000;

    // Reset state and first instruction
    step();
    step();
    check("reset_bus", {bus_req, bus_addr}, {1'b0, 16'h0100});
    check("reset_insn", {insn_valid, insn_op, insn_imm, insn_len, insn_pc},
          {1'b0, 8'h00, 16'h0000, 2'd0, 16'h0000});
    rst = 1'b0;
    step();
    check("first_read", {bus_req, bus_addr}, {1'b1, 16'h0100});
    wait_valid("first_insn");
    check("first_insn", {insn_op, insn_len, insn_imm, insn_pc}, {8'h05, 2'd1, 16'h0000, 16'h0100});
    accept();
    check("first_next", {insn_valid, bus_req, bus_addr}, {1'b0, 1'b1, 16'h0101});

    // Table-driven instructions reached via redirect
    for (int i = 0; i < 5; i++) begin
      redirect(vecs[i].addr);
      wait_valid("vec_valid");
      check($sformatf("vec%0d_insn", i), {insn_op, insn_len, insn_imm, insn_pc},
            {vecs[i].b0, vecs[i].len, vecs[i].imm, vecs[i].addr});
      accept();
      next_addr = vecs[i].addr + {14'd0, vecs[i].len};
      check($sformatf("vec%0d_next", i), {insn_valid, bus_req, bus_addr}, {1'b0, 1'b1, next_addr});
    end

    // Decode stalls: instruction held, no bus activity
    redirect(16'h0400);
    wait_valid("hold_valid");
    snap = {40'd0, insn_op, insn_imm};
    snap = {snap[39:0], 6'd0, insn_len, insn_pc};
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!insn_valid || bus_req || {insn_op, insn_imm, 6'd0, insn_len, insn_pc} != snap[47:0]) ok = 1'b0;
    end
    check("hold_stable", ok, 1'b1);
    check("hold_insn", {insn_op, insn_len, insn_imm, insn_pc}, {8'h41, 2'd2, 16'h0099, 16'h0400});
    accept();
    check("hold_release", {bus_req, bus_addr}, {1'b1, 16'h0402});

    // Redirect in B1 with a slow ack: read drained, data dropped
    redirect(16'h0500);
    wait_addr("b1_reach", 16'h0501);
    ack_delay = 3;
    redirect(16'h0300);
    ok = 1'b1;
    n  = 0;
    while (!(bus_req && bus_addr == 16'h0300) && n < 40) begin
      if (!bus_req || bus_addr != 16'h0501 || insn_valid) ok = 1'b0;
      step();
      n++;
    end
    ack_delay = 1;
    check("drain_held", ok, 1'b1);
    check("drain_cycles", n, 3);
    check("drain_next", {insn_valid, bus_req, bus_addr}, {1'b0, 1'b1, 16'h0300});
    wait_valid("drain_insn");
    check("drain_insn", {insn_op, insn_len, insn_imm, insn_pc}, {8'h01, 2'd1, 16'h0000, 16'h0300});
    accept();

    // Instruction straddling the address wrap
    redirect(16'hFFFF);
    wait_addr("wrap_reach", 16'hFFFF);
    addr_log.delete();
    wait_valid("wrap_valid");
    check("wrap_insn", {insn_op, insn_len, insn_imm, insn_pc}, {8'hC0, 2'd3, 16'hBEEF, 16'hFFFF});
    check("wrap_reads", addr_log.size(), 3);
    if (addr_log.size() == 3)
      check("wrap_addrs", {addr_log[0], addr_log[1], addr_log[2]}, {16'hFFFF, 16'h0000, 16'h0001});
    accept();
    check("wrap_next", {bus_req, bus_addr}, {1'b1, 16'h0002});

    // Handshake and redirect in the same cycle
    wait_valid("hs_redir_valid");
    check("hs_redir_insn", {insn_op, insn_pc}, {8'h00, 16'h0002});
    insn_ready  = 1'b1;
    redir_addr  = 16'h0220;
    redir_valid = 1'b1;
    step();
    insn_ready  = 1'b0;
    redir_valid = 1'b0;
    check("hs_redir_next", {insn_valid, bus_req, bus_addr}, {1'b0, 1'b1, 16'h0220});
    wait_valid("hs_redir_insn2");
    check("hs_redir_insn2", {insn_op, insn_pc}, {8'h3C, 16'h0220});
    accept();

    // Asynchronous reset during B2
    redirect(16'h0600);
    wait_addr("b2_reach", 16'h0602);
    ack_delay = $urandom_range(2, 4);
    rst = 1'b1;
    #1;
    check("rst_async_bus", {bus_req, bus_addr}, {1'b0, 16'h0100});
    check("rst_async_insn", {insn_valid, insn_op, insn_imm, insn_len, insn_pc},
          {1'b0, 8'h00, 16'h0000, 2'd0, 16'h0000});
    step();
    step();
    rst       = 1'b0;
    ack_delay = 1;
    step();
    check("rst_first_read", {bus_req, bus_addr}, {1'b1, 16'h0100});
    wait_valid("rst_insn");
    check("rst_insn", {insn_op, insn_len, insn_pc}, {8'h05, 2'd1, 16'h0100});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
